// File: rtl/num_entry_pkg.sv
// Shared types and display masks for the two-operand number entry sequencer.
package num_entry_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    DONE  = 2'd2
  } entry_state_t;

  localparam logic [7:0] DIG_A_MASK = 8'hF0;
  localparam logic [7:0] DIG_B_MASK = 8'h0F;

  // The field being edited goes dark while blink is off; the other field stays lit.
  function automatic logic [7:0] digit_mask(input entry_state_t s, input logic blink_on);
    case (s)
      SEL_A:   return blink_on ? 8'hFF : DIG_B_MASK;
      SEL_B:   return blink_on ? 8'hFF : DIG_A_MASK;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a debounced button level; history resets high so a
// button held through reset release produces no event.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= d;
  end

  assign rise = d & ~r_prev;

endmodule

// File: rtl/num_entry_ctrl.sv
// Operand entry sequencer: loads A then B from the switches, tracks validity and
// drives per-digit enables so the field being edited blinks on the hex display.
module num_entry_ctrl
  import num_entry_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BLINK_DIV = 50_000_000,
  parameter int CNT_W     = $clog2(BLINK_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             load_a,
  output logic             load_b,
  output logic             valid,
  output logic [7:0]       digit_en,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic w_rise_load, w_rise_next, w_rise_clear;

  rise_edge_det u_det_load  (.clk(clk), .reset(reset), .d(btn_load),  .rise(w_rise_load));
  rise_edge_det u_det_next  (.clk(clk), .reset(reset), .d(btn_next),  .rise(w_rise_next));
  rise_edge_det u_det_clear (.clk(clk), .reset(reset), .d(btn_clear), .rise(w_rise_clear));

  entry_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic             r_load_a, r_load_b, r_valid;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_blink_on, w_blink_nxt;
  logic [7:0]       r_digit_en, w_digit_nxt;
  logic             w_load_a, w_load_b, w_clr, w_restart;

  // Event priority: clear beats load beats next; losers are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_clr       = 1'b0;
    if (w_rise_clear) begin
      w_clr       = 1'b1;
      w_state_nxt = SEL_A;
    end else if (w_rise_load) begin
      case (r_state)
        SEL_A: begin
          w_load_a    = 1'b1;
          w_state_nxt = SEL_B;
        end
        SEL_B: begin
          w_load_b    = 1'b1;
          w_state_nxt = DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end else if (w_rise_next) begin
      case (r_state)
        SEL_A:   w_state_nxt = SEL_B;
        default: w_state_nxt = SEL_A;
      endcase
    end
  end

  // Any state change or clear restarts the blink phase so the new field starts lit.
  always_comb begin
    w_restart   = w_clr | (w_state_nxt != r_state);
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_blink_nxt = r_blink_on;
    if (w_restart) begin
      w_cnt_nxt   = '0;
      w_blink_nxt = 1'b1;
    end else if (r_cnt == LP_CNT_MAX) begin
      w_cnt_nxt   = '0;
      w_blink_nxt = ~r_blink_on;
    end
    w_digit_nxt = digit_mask(w_state_nxt, w_blink_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SEL_A;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_load_a   <= 1'b0;
      r_load_b   <= 1'b0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
      r_blink_on <= 1'b1;
      r_digit_en <= 8'hFF;
    end else begin
      r_state    <= w_state_nxt;
      r_load_a   <= w_load_a;
      r_load_b   <= w_load_b;
      r_cnt      <= w_cnt_nxt;
      r_blink_on <= w_blink_nxt;
      r_digit_en <= w_digit_nxt;
      if (w_clr) begin
        r_op_a  <= '0;
        r_op_b  <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_load_a) r_op_a <= sw;
        if (w_load_b) begin
          r_op_b  <= sw;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign load_a   = r_load_a;
  assign load_b   = r_load_b;
  assign valid    = r_valid;
  assign digit_en = r_digit_en;
  assign state_o  = r_state;

endmodule

// File: tb/tb_num_entry_ctrl.sv
// Directed bench for num_entry_ctrl with a short blink period.
module tb_num_entry_ctrl;

  localparam int WIDTH     = 16;
  localparam int BLINK_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw;
  logic             btn_load, btn_next, btn_clear;
  logic [WIDTH-1:0] op_a, op_b;
  logic             load_a, load_b, valid;
  logic [7:0]       digit_en;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_fail   = 0;

  num_entry_ctrl #(.WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .btn_load(btn_load), .btn_next(btn_next), .btn_clear(btn_clear),
    .op_a(op_a), .op_b(op_b), .load_a(load_a), .load_b(load_b),
    .valid(valid), .digit_en(digit_en), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sw = '0; btn_load = 1'b1; btn_next = 1'b0; btn_clear = 1'b0;
    repeat (3) step();
    check_val("rst_op_a", op_a, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_digit", digit_en, 8'hFF);
    reset = 1'b0;

    // btn_load held through reset release: no event
    step(); check_val("held_load_a_1", load_a, 0);
    step(); check_val("held_load_a_2", load_a, 0);
    btn_load = 1'b0;
    step();
    check_val("held_op_a", op_a, 0);
    check_val("held_state", state_o, 0);
    check_val("held_digit", digit_en, 8'hFF);

    // load A, held two cycles: exactly one pulse and one transition
    sw = 16'h1234; btn_load = 1'b1;
    step();
    check_val("ldA_pulse", load_a, 1);
    check_val("ldA_op_a", op_a, 16'h1234);
    check_val("ldA_state", state_o, 1);
    check_val("ldA_digit", digit_en, 8'hFF);
    step();
    check_val("ldA_pulse_end", load_a, 0);
    check_val("ldA_state_hold", state_o, 1);
    btn_load = 1'b0;
    step();

    // load B
    sw = 16'hABCD; btn_load = 1'b1;
    step();
    check_val("ldB_pulse", load_b, 1);
    check_val("ldB_op_b", op_b, 16'hABCD);
    check_val("ldB_valid", valid, 1);
    check_val("ldB_state", state_o, 2);
    check_val("ldB_digit", digit_en, 8'hFF);
    btn_load = 1'b0;
    step();
    check_val("ldB_pulse_end", load_b, 0);

    // load ignored in DONE
    sw = 16'h5555; btn_load = 1'b1;
    step();
    check_val("done_ld_a", load_a, 0);
    check_val("done_ld_b", load_b, 0);
    check_val("done_op_a", op_a, 16'h1234);
    check_val("done_op_b", op_b, 16'hABCD);
    check_val("done_state", state_o, 2);
    btn_load = 1'b0;
    step();

    // next from DONE re-edits A with values and valid held
    btn_next = 1'b1;
    step();
    check_val("reedit_state", state_o, 0);
    check_val("reedit_valid", valid, 1);
    check_val("reedit_op_a", op_a, 16'h1234);
    check_val("reedit_op_b", op_b, 16'hABCD);
    check_val("reedit_digit", digit_en, 8'hFF);
    btn_next = 1'b0;

    // blink in SEL_A: lit 3 edges after restart, dark for 4, lit again
    for (int i = 1; i <= 12; i++) begin
      step();
      check_val($sformatf("blinkA_%0d", i), digit_en,
                ((i >= 4 && i <= 7) || i == 12) ? 8'h0F : 8'hFF);
    end

    // next while dark: phase restarts lit in SEL_B
    btn_next = 1'b1;
    step();
    check_val("nextB_state", state_o, 1);
    check_val("nextB_digit", digit_en, 8'hFF);
    btn_next = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_val($sformatf("blinkB_%0d", i), digit_en, (i == 4) ? 8'hF0 : 8'hFF);
    end

    // simultaneous clear/load/next: clear wins
    sw = 16'h5555; btn_load = 1'b1; btn_next = 1'b1; btn_clear = 1'b1;
    step();
    check_val("clr_op_a", op_a, 0);
    check_val("clr_op_b", op_b, 0);
    check_val("clr_valid", valid, 0);
    check_val("clr_state", state_o, 0);
    check_val("clr_ld_a", load_a, 0);
    check_val("clr_ld_b", load_b, 0);
    check_val("clr_digit", digit_en, 8'hFF);
    btn_load = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    step();

    // reach SEL_B with op_b loaded: load A, load B, next, next
    sw = 16'h1111; btn_load = 1'b1; step(); btn_load = 1'b0; step();
    sw = 16'h2222; btn_load = 1'b1; step(); btn_load = 1'b0; step();
    btn_next = 1'b1; step(); btn_next = 1'b0; step();
    btn_next = 1'b1; step(); btn_next = 1'b0;
    check_val("pre_rst_state", state_o, 1);
    check_val("pre_rst_op_b", op_b, 16'h2222);
    repeat (4) step();
    check_val("pre_rst_digit", digit_en, 8'hF0);

    // asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    check_val("arst_op_a", op_a, 0);
    check_val("arst_op_b", op_b, 0);
    check_val("arst_valid", valid, 0);
    check_val("arst_state", state_o, 0);
    check_val("arst_digit", digit_en, 8'hFF);
    step();
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
